// File: rtl/sipo_word_collector_if.sv
// rtl/sipo_word_collector_if.sv - byte-in / frame-out handshake bundle for sipo_word_collector
// Purpose: groups the serial byte stream, the assembled frame and the drop pulse.
// Signals:
//   in_data[7:0], in_valid, in_ready        serial byte stream into the collector
//   out_words[NINPUTS-1:0][IWIDTH-1:0]      assembled frame (index 0 = first word)
//   out_valid, out_ready                    frame handshake to the consumer
//   timeout_drop                            one-cycle pulse when a partial frame is discarded
// Modports: slave = collector side, master = producer/consumer side.
interface sipo_word_collector_if #(
  parameter int IWIDTH  = 10,
  parameter int NINPUTS = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [IWIDTH-1:0] out_words [NINPUTS-1:0];
  logic              out_valid;
  logic              out_ready;
  logic              timeout_drop;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_words, out_valid, timeout_drop
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_words, out_valid, timeout_drop
  );
endinterface

// File: rtl/sipo_word_collector.sv
// rtl/sipo_word_collector.sv - assembles little-endian bytes into a frame of NINPUTS words
// Purpose: collects ceil(IWIDTH/8) bytes per word, NINPUTS words per frame, then holds
//          the frame stable with out_valid until the consumer takes it.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   sipo_word_collector_if.slave (in_data/in_valid/in_ready, out_words/out_valid/
//         out_ready, timeout_drop)
// Parameters: IWIDTH (1..32), NINPUTS (>=2), TIMEOUT_CYCLES (>=2)
// Optional feature: define SIPO_COLLECT_TIMEOUT_EN to discard a partial frame after
//                   TIMEOUT_CYCLES idle cycles; otherwise timeout_drop is tied 0.
module sipo_word_collector #(
  parameter int IWIDTH         = 10,
  parameter int NINPUTS        = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  sipo_word_collector_if.slave bus
);
  localparam int BPW = (IWIDTH + 7) / 8;
  localparam int SW  = 8 * BPW;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WW  = $clog2(NINPUTS);

  if (IWIDTH < 1 || IWIDTH > 32 || NINPUTS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("sipo_word_collector: parameter out of range");
  end

  typedef enum logic {COLLECT, FULL} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     byte_idx;
  logic [WW-1:0]     word_idx;
  logic [IWIDTH-1:0] words_q [NINPUTS-1:0];
  logic [IWIDTH-1:0] merged;
  logic [BW+2:0]     shamt;
  logic              in_ready, out_valid;
  logic              accept, last_byte, last_word, frame_done, release_frame;
  logic              timeout_hit;

  // Acceptance is derived from the registered state rather than in_ready to keep
  // the FSM output logic free of a combinational loop through frame_done.
  assign accept        = bus.in_valid && (state_q == COLLECT);
  assign last_byte     = (byte_idx == BW'(BPW - 1));
  assign last_word     = (word_idx == WW'(NINPUTS - 1));
  assign frame_done    = accept && last_byte && last_word;
  assign release_frame = (state_q == FULL) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (frame_done) state_d = FULL;
      end
      FULL: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // Replace only the lane of the current byte; bits above IWIDTH-1 fall off in the cast.
  always_comb begin
    shamt  = {byte_idx, 3'b000};
    merged = (words_q[word_idx] & ~IWIDTH'(SW'(8'hFF) << shamt))
           | IWIDTH'(SW'(bus.in_data) << shamt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx <= '0;
      word_idx <= '0;
      for (int i = 0; i < NINPUTS; i++) words_q[i] <= '0;
    end else if (release_frame || timeout_hit) begin
      byte_idx <= '0;
      word_idx <= '0;
    end else if (accept) begin
      words_q[word_idx] <= merged;
      if (last_byte) begin
        byte_idx <= '0;
        word_idx <= last_word ? '0 : word_idx + WW'(1);
      end else begin
        byte_idx <= byte_idx + BW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_words = words_q;

`ifdef SIPO_COLLECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;
  logic          drop_q;
  logic          partial;

  // A frame is partial once any byte has landed; indices are both zero otherwise.
  assign partial     = (byte_idx != '0) || (word_idx != '0);
  assign timeout_hit = (state_q == COLLECT) && !accept && partial
                     && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= timeout_hit;
      if (accept || timeout_hit || !partial || state_q != COLLECT) idle_cnt <= '0;
      else                                                          idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign bus.timeout_drop = drop_q;
`else
  assign timeout_hit      = 1'b0;
  assign bus.timeout_drop = 1'b0;
`endif
endmodule

// File: doc/sipo_word_collector.md
SIPO_WORD_COLLECTOR -- requirements
Module: sipo_word_collector

Interface
REQ-001 Parameter IWIDTH, default 10, SHALL set the width of each assembled word (1..32).
REQ-002 Parameter NINPUTS, default 8, SHALL set the number of words per frame (>=2).
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, SHALL set the idle limit in clk cycles within a partial frame (>=2).
REQ-004 clk  input  1  clock; all logic SHALL act on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  8  serial byte stream.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block accepts a byte this cycle.
REQ-009 out_words  output  IWIDTH x NINPUTS (unpacked array [NINPUTS-1:0])  assembled frame; index 0 is the first word received.
REQ-010 out_valid  output  1  frame complete and stable.
REQ-011 out_ready  input  1  downstream consumes the frame (drives the serialiser's load).
REQ-012 timeout_drop  output  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-013 BPW = ceil(IWIDTH/8) SHALL be the number of bytes per word.
REQ-014 A byte SHALL be accepted at a rising edge where in_valid && in_ready.
REQ-015 Bytes within a word SHALL be little-endian: the first byte forms bits [7:0], the next [15:8], and so on.
REQ-016 Bits beyond IWIDTH-1 in the last byte SHALL be discarded.
REQ-017 The FSM SHALL have two states: COLLECT (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1).
REQ-018 COLLECT->FULL SHALL occur on acceptance of byte BPW-1 of word NINPUTS-1; out_valid rises and in_ready falls on the next cycle.
REQ-019 FULL->COLLECT SHALL occur on a rising edge with out_valid && out_ready; the byte and word counters clear and in_ready=1 on the next cycle.
REQ-020 In FULL, in_valid SHALL be ignored and out_words SHALL remain bit-stable.
REQ-021 out_ready SHALL be ignored while out_valid=0, including in the cycle the final byte is accepted.
REQ-022 Word index SHALL advance after byte BPW-1; byte index SHALL wrap to 0 at BPW.
REQ-023 out_words entries not yet rewritten in the current frame SHALL keep their previous values; they are meaningful only while out_valid=1.
REQ-024 Minimum frame period SHALL be NINPUTS*BPW accept cycles + 1 FULL cycle (back-to-back when out_ready is held high).
REQ-025 timeout_drop SHALL be 0 except as defined in REQ-031.

Reset
REQ-026 rst SHALL force state COLLECT, byte/word counters 0, out_valid=0, in_ready=1 (from the next cycle), timeout_drop=0, timeout counter 0.
REQ-027 rst SHALL clear out_words to 0.
REQ-028 rst SHALL take priority over every other input, including mid-frame or while FULL; any partial or pending frame is discarded.

Configuration
REQ-029 Macro SIPO_COLLECT_TIMEOUT_EN SHALL control the inter-byte timeout.
REQ-030 With the macro defined: a counter SHALL increment each cycle in COLLECT with at least one byte of the frame accepted and no byte accepted that cycle, and SHALL clear on each acceptance.
REQ-031 With the macro defined: when the counter reaches TIMEOUT_CYCLES, the byte and word counters SHALL clear and timeout_drop SHALL pulse high for exactly one cycle; out_words is left unchanged.
REQ-032 With the macro undefined: no timeout counter SHALL exist, timeout_drop SHALL be tied 0, and partial frames SHALL wait indefinitely.

Verification (IWIDTH=10, NINPUTS=8, BPW=2)
REQ-033 16 bytes: 0x01,0x00,0x02,0x00,...,0x08,0x00 with out_ready=0 -> out_valid=1 one cycle after byte 16; out_words[i]=i+1; in_ready=0; out_valid stays 1 for 100 cycles.
REQ-034 Byte pair 0xFF,0xFF as word 0 -> out_words[0]=0x3FF (upper 6 bits dropped).
REQ-035 While FULL, drive in_valid=1 with 0xAA for 10 cycles -> out_words unchanged; then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 next cycle; the 0xAA bytes were not accepted.
REQ-036 rst pulse after 7 bytes, then 16 new bytes -> frame contains only the new bytes; out_valid only after the 16th new byte.
REQ-037 Macro defined, TIMEOUT_CYCLES=20: 3 bytes then 20 idle cycles -> timeout_drop pulses exactly once; next 16 bytes form a correct frame aligned at word 0 byte 0.
REQ-038 out_ready held 1 with continuous in_valid -> frames every 17 cycles; no byte lost or duplicated across 4 frames.
